// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one RAM port between the icache and dcache of every core.
//   Round-robin between cores, and dcache before icache within a core.
//   A granted access runs IDLE -> BUSY -> DONE. Wait and load are returned
//   to the owner during the single DONE cycle.
// Ports
//   clk, nRST          clock, asynchronous active-low reset
//   iREN/iaddr         per-core icache read request and word address
//   iwait/iload        per-core icache wait flag and read data
//   dREN/dWEN          per-core dcache read and write requests
//   daddr/dstore       per-core dcache address and write data
//   dwait/dload        per-core dcache wait flag and read data
//   ramREN/ramWEN      RAM strobes, driven only in BUSY
//   ramaddr/ramstore   latched RAM address and write data
//   ramload/ram_ready  RAM read data and completion pulse
//   timeout            pulses in DONE when the watchdog aborted the access
module cache_mem_arbiter #(
  parameter int unsigned NCPU    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic [NCPU-1:0]    iREN,
  input  logic [NCPU*32-1:0] iaddr,
  output logic [NCPU-1:0]    iwait,
  output logic [NCPU*32-1:0] iload,
  input  logic [NCPU-1:0]    dREN,
  input  logic [NCPU-1:0]    dWEN,
  input  logic [NCPU*32-1:0] daddr,
  input  logic [NCPU*32-1:0] dstore,
  output logic [NCPU-1:0]    dwait,
  output logic [NCPU*32-1:0] dload,
  output logic               ramREN,
  output logic               ramWEN,
  output logic [31:0]        ramaddr,
  output logic [31:0]        ramstore,
  input  logic [31:0]        ramload,
  input  logic               ram_ready,
  output logic               timeout
);

  localparam int unsigned RW = (NCPU > 1) ? $clog2(NCPU) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nx;
  logic [RW-1:0]      rr, own_core, win_core;
  logic               own_d, own_wr, aborted;
  logic               found, win_d, win_wr, expire, finish;
  logic [31:0]        lat_addr, lat_data, win_addr, win_data, fin_data;
  logic [CW-1:0]      cnt;
  logic [NCPU*32-1:0] iload_q, dload_q;
  int unsigned        sc;

  // Rotating scan starting at rr; the first core with any request wins.
  always_comb begin
    found    = 1'b0;
    win_core = '0;
    win_d    = 1'b0;
    win_wr   = 1'b0;
    win_addr = '0;
    win_data = '0;
    sc       = 0;
    for (int unsigned k = 0; k < NCPU; k++) begin
      sc = (int'(rr) + k) % NCPU;
      if (!found && (dWEN[sc] || dREN[sc] || iREN[sc])) begin
        found    = 1'b1;
        win_core = RW'(sc);
        if (dWEN[sc] || dREN[sc]) begin
          win_d    = 1'b1;
          win_wr   = dWEN[sc];
          win_addr = daddr[sc*32 +: 32];
          win_data = dWEN[sc] ? dstore[sc*32 +: 32] : '0;
        end else begin
          win_addr = iaddr[sc*32 +: 32];
        end
      end
    end
  end

  // ram_ready takes precedence over a watchdog expiry in the same cycle.
  assign expire   = (state == BUSY) && !ram_ready && (TIMEOUT != 0) &&
                    (cnt == CW'(TIMEOUT));
  assign finish   = (state == BUSY) && (ram_ready || expire);
  assign fin_data = (ram_ready && !own_wr) ? ramload : '0;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = BUSY;
      BUSY:    if (ram_ready || expire) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rr       <= '0;
      own_core <= '0;
      own_d    <= 1'b0;
      own_wr   <= 1'b0;
      aborted  <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      cnt      <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      if (state == IDLE && found) begin
        own_core <= win_core;
        own_d    <= win_d;
        own_wr   <= win_wr;
        lat_addr <= win_addr;
        lat_data <= win_data;
        cnt      <= CW'(1);
        aborted  <= 1'b0;
      end
      if (state == BUSY) begin
        cnt <= cnt + CW'(1);
      end
      // Load registers are written on entry to DONE so data is valid with wait low.
      if (finish) begin
        aborted <= !ram_ready;
        if (own_d) dload_q[int'(own_core)*32 +: 32] <= fin_data;
        else       iload_q[int'(own_core)*32 +: 32] <= fin_data;
      end
      if (state == DONE) begin
        rr <= (own_core == RW'(NCPU - 1)) ? '0 : own_core + RW'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NCPU; c++) begin
      iwait[c] = !((state == DONE) && (own_core == RW'(c)) && !own_d);
      dwait[c] = !((state == DONE) && (own_core == RW'(c)) &&  own_d);
    end
  end

  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = (state == BUSY) && !own_wr;
  assign ramWEN   = (state == BUSY) &&  own_wr;
  assign ramaddr  = lat_addr;
  assign ramstore = lat_data;
  assign timeout  = (state == DONE) && aborted;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  logic        clk, nRST;
  logic [1:0]  iREN, iwait, dREN, dWEN, dwait;
  logic [63:0] iaddr, iload, daddr, dstore, dload;
  logic        ramREN, ramWEN, ram_ready, timeout;
  logic [31:0] ramaddr, ramstore, ramload;

  int errors = 0;
  int checks = 0;

  cache_mem_arbiter #(.NCPU(2), .TIMEOUT(8)) dut (
    .clk(clk), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic ready_pulse(input logic [31:0] data);
    ram_ready = 1'b1;
    ramload   = data;
    cyc();
    ram_ready = 1'b0;
    ramload   = '0;
  endtask

  initial begin
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0; ram_ready = 1'b0; ramload = '0;
    cyc();
    chk("rst_iwait",   32'(iwait), 32'h3);
    chk("rst_dwait",   32'(dwait), 32'h3);
    chk("rst_ramREN",  32'(ramREN), 32'h0);
    chk("rst_ramWEN",  32'(ramWEN), 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_iload0",  iload[31:0], 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    nRST = 1'b1;
    cyc();

    // Single icache read on core 0
    iREN[0] = 1'b1; iaddr[31:0] = 32'h40;
    cyc();
    chk("rd_c1_ramREN",  32'(ramREN), 32'h1);
    chk("rd_c1_ramWEN",  32'(ramWEN), 32'h0);
    chk("rd_c1_ramaddr", ramaddr, 32'h40);
    chk("rd_c1_iwait",   32'(iwait), 32'h3);
    cyc();
    chk("rd_c2_ramREN",  32'(ramREN), 32'h1);
    ready_pulse(32'hDEADBEEF);
    chk("rd_c3_iwait",   32'(iwait), 32'h2);
    chk("rd_c3_dwait",   32'(dwait), 32'h3);
    chk("rd_c3_iload0",  iload[31:0], 32'hDEADBEEF);
    chk("rd_c3_ramREN",  32'(ramREN), 32'h0);
    iREN[0] = 1'b0;
    cyc();
    chk("rd_c4_iwait",   32'(iwait), 32'h3);
    chk("rd_c4_iload0",  iload[31:0], 32'hDEADBEEF);

    // Intra-core priority: write before icache read
    iREN[0] = 1'b1; iaddr[31:0] = 32'h44;
    dWEN[0] = 1'b1; daddr[31:0] = 32'h80; dstore[31:0] = 32'h1234;
    cyc();
    chk("pri_ramWEN",   32'(ramWEN), 32'h1);
    chk("pri_ramREN",   32'(ramREN), 32'h0);
    chk("pri_ramaddr",  ramaddr, 32'h80);
    chk("pri_ramstore", ramstore, 32'h1234);
    ready_pulse(32'hAAAA);
    chk("pri_wr_dwait", 32'(dwait), 32'h2);
    chk("pri_wr_iwait", 32'(iwait), 32'h3);
    chk("pri_wr_dload", dload[31:0], 32'h0);
    dWEN[0] = 1'b0;
    cyc();
    cyc();
    chk("pri_rd_ramREN",  32'(ramREN), 32'h1);
    chk("pri_rd_ramaddr", ramaddr, 32'h44);
    ready_pulse(32'h5555);
    chk("pri_rd_iwait", 32'(iwait), 32'h2);
    chk("pri_rd_iload", iload[31:0], 32'h5555);
    iREN[0] = 1'b0;
    cyc();

    // Stability: address change in BUSY ignored, spurious ram_ready in IDLE ignored
    dREN[0] = 1'b1; daddr[31:0] = 32'h600;
    cyc();
    chk("stab_addr0", ramaddr, 32'h600);
    daddr[31:0] = 32'h700;
    cyc();
    chk("stab_addr1", ramaddr, 32'h600);
    ready_pulse(32'h66);
    chk("stab_dload", dload[31:0], 32'h66);
    dREN[0] = 1'b0;
    cyc();
    ram_ready = 1'b1; ramload = 32'hBAD;
    cyc();
    chk("spur_iwait",  32'(iwait), 32'h3);
    chk("spur_dwait",  32'(dwait), 32'h3);
    chk("spur_ramREN", 32'(ramREN), 32'h0);
    cyc();
    chk("spur_dwait2", 32'(dwait), 32'h3);
    chk("spur_dload",  dload[31:0], 32'h66);
    ram_ready = 1'b0; ramload = '0;

    // Reset asserted mid-BUSY drops strobes immediately
    dREN[1] = 1'b1; daddr[63:32] = 32'h900;
    cyc();
    chk("mid_busy_ramREN", 32'(ramREN), 32'h1);
    #1 nRST = 1'b0;
    #1;
    chk("mid_rst_ramREN",  32'(ramREN), 32'h0);
    chk("mid_rst_ramaddr", ramaddr, 32'h0);
    chk("mid_rst_dwait",   32'(dwait), 32'h3);
    chk("mid_rst_iwait",   32'(iwait), 32'h3);
    dREN[1] = 1'b0;
    cyc();
    nRST = 1'b1;
    cyc();
    chk("post_rst_ramREN", 32'(ramREN), 32'h0);
    chk("post_rst_dwait",  32'(dwait), 32'h3);

    // Round-robin: both cores hold dREN, owners alternate 0,1,0,1
    dREN = 2'b11; daddr[31:0] = 32'h100; daddr[63:32] = 32'h200;
    for (int t = 0; t < 4; t++) begin
      cyc();
      chk("rr_ramREN",  32'(ramREN), 32'h1);
      chk("rr_ramaddr", ramaddr, (t % 2 == 0) ? 32'h100 : 32'h200);
      ready_pulse(32'hC000 + 32'(t));
      chk("rr_dwait", 32'(dwait), (t % 2 == 0) ? 32'h2 : 32'h1);
      if (t % 2 == 0) chk("rr_dload0", dload[31:0],  32'hC000 + 32'(t));
      else            chk("rr_dload1", dload[63:32], 32'hC000 + 32'(t));
      cyc();
    end
    dREN = '0;
    cyc();

    // Watchdog: no ram_ready, abort after 8 BUSY cycles
    dREN[1] = 1'b1; daddr[63:32] = 32'h300;
    cyc();
    chk("wd_busy1", 32'(ramREN), 32'h1);
    for (int b = 2; b <= 8; b++) begin
      cyc();
      chk("wd_busy", 32'(ramREN), 32'h1);
      chk("wd_busy_timeout", 32'(timeout), 32'h0);
    end
    cyc();
    chk("wd_timeout", 32'(timeout), 32'h1);
    chk("wd_dwait",   32'(dwait), 32'h1);
    chk("wd_dload1",  dload[63:32], 32'h0);
    chk("wd_ramREN",  32'(ramREN), 32'h0);
    dREN[1] = 1'b0;
    cyc();
    chk("wd_timeout_clr", 32'(timeout), 32'h0);
    iREN[0] = 1'b1; iaddr[31:0] = 32'h500;
    cyc();
    chk("wd_next_ramREN",  32'(ramREN), 32'h1);
    chk("wd_next_ramaddr", ramaddr, 32'h500);
    ready_pulse(32'h77);
    chk("wd_next_iwait",   32'(iwait), 32'h2);
    chk("wd_next_iload",   iload[31:0], 32'h77);
    chk("wd_next_timeout", 32'(timeout), 32'h0);
    iREN[0] = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
